axi_lite_arbiter_2to1: RTL and testbench

//  Shares one AXI4-Lite slave (UART Lite register file) between two AXI4-Lite masters.

---
 rtl/axi_lite_arbiter_2to1.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_arbiter_2to1.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter_2to1.sv
// rtl/axi_lite_arbiter_2to1.sv - round-robin 2:1 AXI4-Lite arbiter, one transaction outstanding
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    // upstream master port 0
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [2:0]              s0_axi_awprot,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic [2:0]              s0_axi_arprot,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    // upstream master port 1
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [2:0]              s1_axi_awprot,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic [2:0]              s1_axi_arprot,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,
    // downstream slave port
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    // status
    output logic [1:0]              grant,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;       // index of the granted port while not IDLE
    logic   rr_ptr, rr_ptr_nxt;     // port preferred on the next simultaneous request
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;

    logic   own0, own1;
    logic   sel1;
    logic   sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic   req0, req1, pick;

    // Ownership decode; payload mux falls back to port 0 while idle.
    always_comb begin
        busy  = (state != IDLE);
        own0  = busy & ~owner;
        own1  = busy & owner;
        sel1  = own1;
        grant = {own1, own0};
    end

    // Select the granted port's handshake inputs and forward its payload downstream.
    always_comb begin
        sel_awvalid  = sel1 ? s1_axi_awvalid : s0_axi_awvalid;
        sel_wvalid   = sel1 ? s1_axi_wvalid  : s0_axi_wvalid;
        sel_bready   = sel1 ? s1_axi_bready  : s0_axi_bready;
        sel_arvalid  = sel1 ? s1_axi_arvalid : s0_axi_arvalid;
        sel_rready   = sel1 ? s1_axi_rready  : s0_axi_rready;
        m_axi_awaddr = sel1 ? s1_axi_awaddr  : s0_axi_awaddr;
        m_axi_awprot = sel1 ? s1_axi_awprot  : s0_axi_awprot;
        m_axi_wdata  = sel1 ? s1_axi_wdata   : s0_axi_wdata;
        m_axi_wstrb  = sel1 ? s1_axi_wstrb   : s0_axi_wstrb;
        m_axi_araddr = sel1 ? s1_axi_araddr  : s0_axi_araddr;
        m_axi_arprot = sel1 ? s1_axi_arprot  : s0_axi_arprot;
    end

    // Downstream valid/ready: only in the matching phase, and AW/W masked once accepted.
    always_comb begin
        m_axi_awvalid = (state == WR_ADDR) & sel_awvalid & ~aw_done;
        m_axi_wvalid  = (state == WR_ADDR) & sel_wvalid  & ~w_done;
        m_axi_bready  = (state == WR_RESP) & sel_bready;
        m_axi_arvalid = (state == RD_ADDR) & sel_arvalid;
        m_axi_rready  = (state == RD_DATA) & sel_rready;
        aw_hs         = m_axi_awvalid & m_axi_awready;
        w_hs          = m_axi_wvalid  & m_axi_wready;
        b_hs          = m_axi_bvalid  & m_axi_bready;
        ar_hs         = m_axi_arvalid & m_axi_arready;
        r_hs          = m_axi_rvalid  & m_axi_rready;
    end

    // Route downstream readies and responses back to the granted port only.
    always_comb begin
        s0_axi_awready = own0 & (state == WR_ADDR) & ~aw_done & m_axi_awready;
        s0_axi_wready  = own0 & (state == WR_ADDR) & ~w_done  & m_axi_wready;
        s0_axi_bvalid  = own0 & (state == WR_RESP) & m_axi_bvalid;
        s0_axi_bresp   = (own0 && state == WR_RESP) ? m_axi_bresp : 2'b00;
        s0_axi_arready = own0 & (state == RD_ADDR) & m_axi_arready;
        s0_axi_rvalid  = own0 & (state == RD_DATA) & m_axi_rvalid;
        s0_axi_rdata   = (own0 && state == RD_DATA) ? m_axi_rdata : '0;
        s0_axi_rresp   = (own0 && state == RD_DATA) ? m_axi_rresp : 2'b00;

        s1_axi_awready = own1 & (state == WR_ADDR) & ~aw_done & m_axi_awready;
        s1_axi_wready  = own1 & (state == WR_ADDR) & ~w_done  & m_axi_wready;
        s1_axi_bvalid  = own1 & (state == WR_RESP) & m_axi_bvalid;
        s1_axi_bresp   = (own1 && state == WR_RESP) ? m_axi_bresp : 2'b00;
        s1_axi_arready = own1 & (state == RD_ADDR) & m_axi_arready;
        s1_axi_rvalid  = own1 & (state == RD_DATA) & m_axi_rvalid;
        s1_axi_rdata   = (own1 && state == RD_DATA) ? m_axi_rdata : '0;
        s1_axi_rresp   = (own1 && state == RD_DATA) ? m_axi_rresp : 2'b00;
    end

    // Next-state logic: arbitrate in IDLE, track AW/W completion, release on response.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        req0        = s0_axi_awvalid | s0_axi_arvalid;
        req1        = s1_axi_awvalid | s1_axi_arvalid;
        pick        = (req0 & req1) ? rr_ptr : req1;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    owner_nxt = pick;
                    // A port offering both a write and a read has its write served first.
                    if (pick ? s1_axi_awvalid : s0_axi_awvalid) begin
                        state_nxt = WR_ADDR;
                    end else begin
                        state_nxt = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    state_nxt   = WR_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_done | aw_hs;
                    w_done_nxt  = w_done | w_hs;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = ~owner;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = ~owner;
                end
            end
            default: begin
                state_nxt   = IDLE;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_ptr  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_ptr  <= rr_ptr_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// tb/tb_axi_lite_arbiter_2to1.sv - self-checking bench for axi_lite_arbiter_2to1
module tb_axi_lite_arbiter_2to1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [AW-1:0] S0_AWADDR = 32'h0000_0004;
    localparam logic [AW-1:0] S1_AWADDR = 32'h0000_0008;
    localparam logic [DW-1:0] S0_WDATA  = 32'h0000_00A5;
    localparam logic [DW-1:0] S1_WDATA  = 32'h0000_005A;
    localparam logic [AW-1:0] S0_ARADDR = 32'h0000_0010;
    localparam logic [AW-1:0] S1_ARADDR = 32'h0000_0014;
    localparam logic [DW-1:0] M_RDATA   = 32'hCAFE_0123;

    logic clk;
    logic s_axi_aresetn;

    logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, m_axi_awaddr;
    logic [2:0]    s0_axi_awprot, s1_axi_awprot, m_axi_awprot;
    logic          s0_axi_awvalid, s1_axi_awvalid, m_axi_awvalid;
    logic          s0_axi_awready, s1_axi_awready, m_axi_awready;
    logic [DW-1:0] s0_axi_wdata, s1_axi_wdata, m_axi_wdata;
    logic [DW/8-1:0] s0_axi_wstrb, s1_axi_wstrb, m_axi_wstrb;
    logic          s0_axi_wvalid, s1_axi_wvalid, m_axi_wvalid;
    logic          s0_axi_wready, s1_axi_wready, m_axi_wready;
    logic [1:0]    s0_axi_bresp, s1_axi_bresp, m_axi_bresp;
    logic          s0_axi_bvalid, s1_axi_bvalid, m_axi_bvalid;
    logic          s0_axi_bready, s1_axi_bready, m_axi_bready;
    logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
    logic [2:0]    s0_axi_arprot, s1_axi_arprot, m_axi_arprot;
    logic          s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
    logic          s0_axi_arready, s1_axi_arready, m_axi_arready;
    logic [DW-1:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
    logic [1:0]    s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
    logic          s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
    logic          s0_axi_rready, s1_axi_rready, m_axi_rready;
    logic [1:0]    grant;
    logic          busy;

    axi_lite_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
        .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awprot(s0_axi_awprot),
        .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
        .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
        .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
        .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready),
        .s0_axi_araddr(s0_axi_araddr), .s0_axi_arprot(s0_axi_arprot),
        .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
        .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
        .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
        .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awprot(s1_axi_awprot),
        .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
        .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
        .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
        .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready),
        .s1_axi_araddr(s1_axi_araddr), .s1_axi_arprot(s1_axi_arprot),
        .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
        .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
        .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle vector. Bit packing:
    //   i0/i1 (master -> arb) = {awvalid, wvalid, bready, arvalid, rready}
    //   mi    (slave -> arb)  = {awready, wready, bvalid, arready, rvalid}
    //   mo    (arb -> slave)  = {awvalid, wvalid, bready, arvalid, rready}
    //   o0/o1 (arb -> master) = {awready, wready, bvalid, arready, rvalid}
    //   rd    = which upstream port must carry the read data {s1,s0}
    typedef struct {
        bit         rst;
        logic [4:0] i0, i1, mi;
        logic [1:0] grant;
        logic       busy;
        logic [4:0] mo, o0, o1;
        logic [1:0] rd;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, logic [4:0] i0, logic [4:0] i1, logic [4:0] mi,
                                logic [1:0] g, logic b, logic [4:0] mo, logic [4:0] o0,
                                logic [4:0] o1, logic [1:0] rd);
        vec_t v;
        v.rst = r; v.i0 = i0; v.i1 = i1; v.mi = mi; v.grant = g; v.busy = b;
        v.mo = mo; v.o0 = o0; v.o1 = o1; v.rd = rd;
        return v;
    endfunction

    task automatic clear_inputs();
        {s0_axi_awvalid, s0_axi_wvalid, s0_axi_bready, s0_axi_arvalid, s0_axi_rready} = '0;
        {s1_axi_awvalid, s1_axi_wvalid, s1_axi_bready, s1_axi_arvalid, s1_axi_rready} = '0;
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
    endtask

    task automatic do_reset();
        s_axi_aresetn = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        s_axi_aresetn = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        {s0_axi_awvalid, s0_axi_wvalid, s0_axi_bready, s0_axi_arvalid, s0_axi_rready} = v.i0;
        {s1_axi_awvalid, s1_axi_wvalid, s1_axi_bready, s1_axi_arvalid, s1_axi_rready} = v.i1;
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = v.mi;
    endtask

    initial begin
        int n0, n1, b0, b1, nh, cyc;
        bit bpend;

        s_axi_aresetn = 1'b0;
        s0_axi_awaddr = S0_AWADDR; s1_axi_awaddr = S1_AWADDR;
        s0_axi_wdata  = S0_WDATA;  s1_axi_wdata  = S1_WDATA;
        s0_axi_araddr = S0_ARADDR; s1_axi_araddr = S1_ARADDR;
        s0_axi_awprot = 3'd0; s1_axi_awprot = 3'd0; s0_axi_arprot = 3'd0; s1_axi_arprot = 3'd0;
        s0_axi_wstrb  = 4'hF; s1_axi_wstrb  = 4'hF;
        m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = M_RDATA;
        clear_inputs();

        // Reset state
        #2;
        check("rst grant", grant, 2'b00);
        check("rst busy", busy, 1'b0);
        check("rst m_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);

        // Single s0 write: downstream valid one cycle after upstream valid
        vecs.push_back(mk(1, 5'b11100, 5'b00000, 5'b11000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b11100, 5'b00000, 5'b11000, 2'b01, 1, 5'b11000, 5'b11000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 2'b01, 1, 5'b00100, 5'b00100, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        // Simultaneous reads after reset: s0 first, then s1
        vecs.push_back(mk(1, 5'b00011, 5'b00011, 5'b00010, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00011, 5'b00011, 5'b00010, 2'b01, 1, 5'b00010, 5'b00010, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00001, 5'b00011, 5'b00011, 2'b01, 1, 5'b00001, 5'b00001, 5'b00000, 2'b01));
        vecs.push_back(mk(0, 5'b00000, 5'b00011, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b00011, 5'b00010, 2'b10, 1, 5'b00010, 5'b00000, 5'b00010, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b00001, 5'b00001, 2'b10, 1, 5'b00001, 5'b00000, 5'b00001, 2'b10));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        // s1 W three cycles ahead of AW, wready held low four cycles; AW kept high to probe masking
        vecs.push_back(mk(1, 5'b00000, 5'b01000, 5'b10000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b01000, 5'b10000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b01000, 5'b10000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b11100, 5'b10000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b11100, 5'b10000, 2'b10, 1, 5'b11000, 5'b00000, 5'b10000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b11100, 5'b10000, 2'b10, 1, 5'b01000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b11100, 5'b10000, 2'b10, 1, 5'b01000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b11100, 5'b10000, 2'b10, 1, 5'b01000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b11100, 5'b11000, 2'b10, 1, 5'b01000, 5'b00000, 5'b01000, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b00100, 5'b00100, 2'b10, 1, 5'b00100, 5'b00000, 5'b00100, 2'b00));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        // s0 write+read together: write first, then s1 read (rr), then s0 read
        vecs.push_back(mk(1, 5'b11110, 5'b00010, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b11110, 5'b00010, 5'b11000, 2'b01, 1, 5'b11000, 5'b11000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00110, 5'b00010, 5'b00100, 2'b01, 1, 5'b00100, 5'b00100, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00010, 5'b00010, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00010, 5'b00010, 5'b00010, 2'b10, 1, 5'b00010, 5'b00000, 5'b00010, 2'b00));
        vecs.push_back(mk(0, 5'b00010, 5'b00001, 5'b00001, 2'b10, 1, 5'b00001, 5'b00000, 5'b00001, 2'b10));
        vecs.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00010, 5'b00000, 5'b00010, 2'b01, 1, 5'b00010, 5'b00010, 5'b00000, 2'b00));
        vecs.push_back(mk(0, 5'b00001, 5'b00000, 5'b00001, 2'b01, 1, 5'b00001, 5'b00001, 5'b00000, 2'b01));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 2'b00, 0, 5'b00000, 5'b00000, 5'b00000, 2'b00));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else @(negedge clk);
            apply(vecs[i]);
            #2;
            check($sformatf("v%0d grant", i), grant, vecs[i].grant);
            check($sformatf("v%0d busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d m_ctl", i),
                  {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, vecs[i].mo);
            check($sformatf("v%0d s0_ctl", i),
                  {s0_axi_awready, s0_axi_wready, s0_axi_bvalid, s0_axi_arready, s0_axi_rvalid}, vecs[i].o0);
            check($sformatf("v%0d s1_ctl", i),
                  {s1_axi_awready, s1_axi_wready, s1_axi_bvalid, s1_axi_arready, s1_axi_rvalid}, vecs[i].o1);
            check($sformatf("v%0d s0_rdata", i), s0_axi_rdata, vecs[i].rd[0] ? M_RDATA : 32'h0);
            check($sformatf("v%0d s1_rdata", i), s1_axi_rdata, vecs[i].rd[1] ? M_RDATA : 32'h0);
            check($sformatf("v%0d m_awaddr", i), m_axi_awaddr, (vecs[i].grant == 2'b10) ? S1_AWADDR : S0_AWADDR);
            check($sformatf("v%0d m_wdata", i), m_axi_wdata, (vecs[i].grant == 2'b10) ? S1_WDATA : S0_WDATA);
            check($sformatf("v%0d m_araddr", i), m_axi_araddr, (vecs[i].grant == 2'b10) ? S1_ARADDR : S0_ARADDR);
        end

        // Both ports stream 8 writes each: grants must alternate starting at s0
        do_reset();
        n0 = 0; n1 = 0; b0 = 0; b1 = 0; nh = 0; cyc = 0; bpend = 1'b0;
        while ((b0 + b1 < 16) && cyc < 400) begin
            @(negedge clk);
            s0_axi_awvalid = (n0 < 8); s0_axi_wvalid = (n0 < 8); s0_axi_bready = 1'b1;
            s1_axi_awvalid = (n1 < 8); s1_axi_wvalid = (n1 < 8); s1_axi_bready = 1'b1;
            m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = bpend;
            #2;
            if (m_axi_bvalid && m_axi_bready) bpend = 1'b0;
            if (m_axi_awvalid && m_axi_awready && m_axi_wvalid && m_axi_wready) bpend = 1'b1;
            if (s0_axi_awvalid && s0_axi_awready) begin
                check($sformatf("alt h%0d port", nh), 0, nh % 2);
                check($sformatf("alt h%0d grant", nh), grant, 2'b01);
                nh++; n0++;
            end
            if (s1_axi_awvalid && s1_axi_awready) begin
                check($sformatf("alt h%0d port", nh), 1, nh % 2);
                check($sformatf("alt h%0d grant", nh), grant, 2'b10);
                nh++; n1++;
            end
            if (s0_axi_bvalid && s0_axi_bready) b0++;
            if (s1_axi_bvalid && s1_axi_bready) b1++;
            cyc++;
        end
        check("alt timeout", (cyc < 400), 1);
        check("alt s0 bresp count", b0, 8);
        check("alt s1 bresp count", b1, 8);
        check("alt aw count", nh, 16);

        // Reset asserted in RD_DATA with rvalid pending, then a fresh s1 read
        do_reset();
        @(negedge clk);
        s0_axi_arvalid = 1'b1; m_axi_arready = 1'b1;
        #2;
        check("rr6 idle busy", busy, 1'b0);
        @(negedge clk);
        #2;
        check("rr6 rd_addr grant", grant, 2'b01);
        check("rr6 rd_addr m_arvalid", m_axi_arvalid, 1'b1);
        @(negedge clk);
        s0_axi_arvalid = 1'b0; m_axi_rvalid = 1'b1;
        #2;
        check("rr6 rd_data s0_rvalid", s0_axi_rvalid, 1'b1);
        s_axi_aresetn = 1'b0;
        #1;
        check("rr6 async grant", grant, 2'b00);
        check("rr6 async busy", busy, 1'b0);
        check("rr6 async s0_rvalid", s0_axi_rvalid, 1'b0);
        check("rr6 async m_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        @(negedge clk);
        clear_inputs();
        s_axi_aresetn = 1'b1;
        @(negedge clk);
        s1_axi_arvalid = 1'b1; s1_axi_rready = 1'b1; m_axi_arready = 1'b1;
        #2;
        check("rr6 s1 idle busy", busy, 1'b0);
        @(negedge clk);
        #2;
        check("rr6 s1 grant", grant, 2'b10);
        check("rr6 s1 m_araddr", m_axi_araddr, S1_ARADDR);
        check("rr6 s1 arready", s1_axi_arready, 1'b1);
        @(negedge clk);
        s1_axi_arvalid = 1'b0; m_axi_rvalid = 1'b1;
        #2;
        check("rr6 s1 rvalid", s1_axi_rvalid, 1'b1);
        check("rr6 s1 rdata", s1_axi_rdata, M_RDATA);
        check("rr6 s1 m_rready", m_axi_rready, 1'b1);
        check("rr6 s0 rvalid quiet", s0_axi_rvalid, 1'b0);
        @(negedge clk);
        m_axi_rvalid = 1'b0; s1_axi_rready = 1'b0;
        #2;
        check("rr6 s1 done busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
